// File: rtl/karat_mult_sched.sv
// -----------------------------------------------------------------------------
// karat_mult_sched
//   Shares one external multiplier among NREQ requesters. A round-robin
//   arbiter accepts one operand pair at a time, launches the multiplier with a
//   single-cycle start pulse, waits (bounded by TMO cycles) for the done flag
//   and presents the product on a valid/ready response port tagged with the
//   owner's index. Only one multiplication is ever outstanding.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake; ready is one-hot or zero
//   req_x, req_y          packed operands, requester i in bits [i*W +: W]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_o         owner index and 2*W-bit product
//   rsp_err               response ended by timeout (rsp_o is zero then)
//   mul_x, mul_y          operands to the multiplier
//   mul_start             one-cycle launch pulse
//   mul_done, mul_o       multiplier finish flag and product
//   op_cnt                completed non-error responses, wraps at 16 bits
// -----------------------------------------------------------------------------
module karat_mult_sched #(
    parameter  int NREQ = 4,
    parameter  int W    = 32,
    parameter  int TMO  = 64,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW   = $clog2(TMO)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*W-1:0]    rsp_o,
    output logic              rsp_err,
    output logic [W-1:0]      mul_x,
    output logic [W-1:0]      mul_y,
    output logic              mul_start,
    input  logic              mul_done,
    input  logic [2*W-1:0]    mul_o,
    output logic [15:0]       op_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_idx;
    logic           grant_hit;
    logic [W-1:0]   grant_x, grant_y;
    logic [W-1:0]   x_q, y_q;
    logic [CW-1:0]  wait_cnt;
    logic           timeout;

    // Round-robin pick. Both loops scan downward so the last hit is the
    // lowest index; the upper half (above last_grant) runs second and so
    // overrides any wrapped-around candidate.
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips the assignment would infer a latch.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        grant_x   = '0;
        grant_y   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i <= int'(last_grant))) begin
                grant_hit = 1'b1;
                grant_idx = IDW'(i);
                grant_x   = req_x[i*W +: W];
                grant_y   = req_y[i*W +: W];
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i > int'(last_grant))) begin
                grant_hit = 1'b1;
                grant_idx = IDW'(i);
                grant_x   = req_x[i*W +: W];
                grant_y   = req_y[i*W +: W];
            end
        end
    end

    // mul_done wins over the timeout on the final wait cycle.
    assign timeout = (state == WAIT) && !mul_done && (wait_cnt == CW'(TMO - 1));

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (grant_hit)           state_nx = ISSUE;
            ISSUE:                            state_nx = WAIT;
            WAIT:    if (mul_done || timeout) state_nx = RESP;
            RESP:    if (rsp_ready)           state_nx = IDLE;
            default:                          state_nx = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE && grant_hit) ? (NREQ'(1) << grant_idx) : '0;
    assign mul_start = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign mul_x     = (state == ISSUE || state == WAIT) ? x_q : '0;
    assign mul_y     = (state == ISSUE || state == WAIT) ? y_q : '0;

    // NOTE: the operand latches are reset as well, so a reset mid-operation
    // leaves no stale data behind even though mul_x/mul_y are gated by state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            rsp_id     <= '0;
            rsp_o      <= '0;
            rsp_err    <= 1'b0;
            wait_cnt   <= '0;
            op_cnt     <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_hit) begin
                        x_q    <= grant_x;
                        y_q    <= grant_y;
                        rsp_id <= grant_idx;
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (mul_done) begin
                        rsp_o   <= mul_o;
                        rsp_err <= 1'b0;
                    end else if (timeout) begin
                        rsp_o   <= '0;
                        rsp_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        last_grant <= rsp_id;
                        if (!rsp_err) op_cnt <= op_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/karat_mult_sched.md
KARAT_MULT_SCHED -- requirements
Module: karat_mult_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one multiplier.
REQ-002 SHALL have parameter W, default 32: operand width; product width is 2*W.
REQ-003 SHALL have parameter TMO, default 64: maximum cycles spent waiting for mul_done, TMO >= 2.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, NREQ: bit i means requester i presents operands.
REQ-007 SHALL have port req_ready, output, NREQ: at most one bit high; bit i high means requester i is accepted this cycle.
REQ-008 SHALL have port req_x, input, NREQ*W: requester i operand X in bits [i*W +: W].
REQ-009 SHALL have port req_y, input, NREQ*W: requester i operand Y in bits [i*W +: W].
REQ-010 SHALL have port rsp_valid, output, 1: response available.
REQ-011 SHALL have port rsp_ready, input, 1: consumer accepts the response.
REQ-012 SHALL have port rsp_id, output, clog2(NREQ) (minimum 1): index of the requester that owns the response.
REQ-013 SHALL have port rsp_o, output, 2*W: product.
REQ-014 SHALL have port rsp_err, output, 1: response was terminated by timeout.
REQ-015 SHALL have port mul_x / mul_y, output, W each: operands driven to the multiplier.
REQ-016 SHALL have port mul_start, output, 1: one-cycle enable pulse to the multiplier.
REQ-017 SHALL have port mul_done, input, 1: multiplier finish flag.
REQ-018 SHALL have port mul_o, input, 2*W: multiplier product.
REQ-019 SHALL have port op_cnt, output, 16: count of completed non-error responses, wrapping at 65535->0.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; only one multiplication is outstanding at a time.
REQ-021 SHALL, in IDLE with any req_valid high, grant round-robin: search from (last_grant+1) mod NREQ upward; assert req_ready only for the granted requester, combinationally in that cycle; latch its X, Y and id; go to ISSUE.
REQ-022 SHALL keep req_ready all-zero in every state other than IDLE, and in IDLE with no req_valid high.
REQ-023 SHALL, in ISSUE, drive mul_start=1 for exactly one cycle, then go to WAIT, clearing the wait counter.
REQ-024 SHALL hold mul_x/mul_y at the latched operands from ISSUE until leaving WAIT, and drive them to zero in IDLE.
REQ-025 SHALL, in WAIT, capture mul_o into rsp_o on the first cycle mul_done=1, set rsp_err=0, and go to RESP.
REQ-026 SHALL, in WAIT, go to RESP with rsp_o=0 and rsp_err=1 when the counter reaches TMO-1 with mul_done low. mul_done on that same cycle takes priority, giving a normal response.
REQ-027 SHALL ignore mul_done in IDLE, ISSUE and RESP.
REQ-028 SHALL, in RESP, hold rsp_valid=1 with stable rsp_o, rsp_id and rsp_err until rsp_ready=1; on that cycle it goes to IDLE, increments op_cnt if rsp_err=0, and updates last_grant to rsp_id.
REQ-029 SHALL, after the RESP handshake, allow a new grant no earlier than the following IDLE cycle (no IDLE bypass).
REQ-030 SHALL give minimum latency: accept at cycle T; mul_start at T+1; mul_done at the earliest T+2; rsp_valid from T+3.

Reset
REQ-031 SHALL, while rst_n=0, force state IDLE and set req_ready=0, rsp_valid=0, rsp_o=0, rsp_id=0, rsp_err=0, mul_start=0, mul_x=mul_y=0, op_cnt=0, and last_grant=NREQ-1, so requester 0 has first priority.
REQ-032 SHALL, on reset asserted mid-operation, drop any in-flight result; a mul_done arriving after reset release SHALL be ignored.

Verification
REQ-033 SHALL cover single request: req_valid=0001, X=3, Y=5, mul_done 4 cycles after mul_start -> req_ready=0001 for 1 cycle, one mul_start pulse, rsp_o=15, rsp_id=0, rsp_err=0, op_cnt=1.
REQ-034 SHALL cover fairness: req_valid=1111 held for 8 transactions with rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3.
REQ-035 SHALL cover backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_o and rsp_id stable; req_ready stays 0; no mul_start.
REQ-036 SHALL cover timeout: TMO=64, mul_done never asserted -> RESP after 64 WAIT cycles with rsp_err=1, rsp_o=0, op_cnt unchanged; a simultaneous done on the last cycle gives rsp_err=0.
REQ-037 SHALL cover reset in WAIT followed by mul_done after release -> no rsp_valid; all outputs at reset values; next grant goes to requester 0.
REQ-038 SHALL cover boundaries: W=32, X=Y=0xFFFFFFFF -> rsp_o=0xFFFFFFFE00000001; op_cnt preset via 65535 completions wraps to 0.
